// File: rtl/cordic_pkg.sv
// ----------------------------------------------------------------------------
// cordic_pkg
//   Shared definitions for the hyperbolic CORDIC arbiter slice.
//   - FUNC_EXP / FUNC_LN : function select encodings for the CORDIC core
//   - TAG_ID_W           : widest requester ID a tag can carry (up to 8 requesters)
//   - tag_t              : {vld, id} travelling alongside an op in the core
//   - cordic_latency()   : core start -> valid latency for a given core width
// ----------------------------------------------------------------------------
package cordic_pkg;

  localparam logic FUNC_EXP = 1'b0;
  localparam logic FUNC_LN  = 1'b1;

  localparam int TAG_ID_W = 3;

  typedef struct packed {
    logic                vld;
    logic [TAG_ID_W-1:0] id;
  } tag_t;

  function automatic int cordic_latency(input int w);
    return w + 3;
  endfunction

endpackage

// File: rtl/pipeline_registers.sv
// ----------------------------------------------------------------------------
// pipeline_registers
//   Plain delay line: data_in appears on data_out NUMBER_OF_STAGES cycles later.
//   Ports:
//     clk      : rising-edge clock
//     rst_n    : asynchronous active-low reset, clears every stage
//     data_in  : BIT_WIDTH-bit value captured each cycle
//     data_out : value from the last stage
// ----------------------------------------------------------------------------
module pipeline_registers #(
  parameter int BIT_WIDTH        = 1,
  parameter int NUMBER_OF_STAGES = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [BIT_WIDTH-1:0] data_in,
  output logic [BIT_WIDTH-1:0] data_out
);

  logic [BIT_WIDTH-1:0] stage_q [NUMBER_OF_STAGES];
  logic [BIT_WIDTH-1:0] stage_d [NUMBER_OF_STAGES];

  // Each stage takes the value of the one before it; stage 0 takes the input.
  always_comb begin
    stage_d[0] = data_in;
    for (int s = 1; s < NUMBER_OF_STAGES; s++) begin
      stage_d[s] = stage_q[s-1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int s = 0; s < NUMBER_OF_STAGES; s++) begin
        stage_q[s] <= '0;
      end
    end else begin
      for (int s = 0; s < NUMBER_OF_STAGES; s++) begin
        stage_q[s] <= stage_d[s];
      end
    end
  end

  assign data_out = stage_q[NUMBER_OF_STAGES-1];

endmodule

// File: rtl/rr_arbiter.sv
// ----------------------------------------------------------------------------
// rr_arbiter
//   Round-robin arbiter. The grant is combinational from the request vector and
//   the registered pointer; the pointer moves to the grantee when advance=1.
//   After reset the pointer sits on N-1 so requester 0 wins first.
//   Ports:
//     clk, rst : clock and synchronous active-high reset
//     req      : N request lines
//     advance  : commit the current grant (pointer <- grantee)
//     gnt      : one-hot grant (all zero when nothing requests)
//     gnt_id   : binary index of the grantee
// ----------------------------------------------------------------------------
module rr_arbiter #(
  parameter int N = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N-1:0]         req,
  input  logic                 advance,
  output logic [N-1:0]         gnt,
  output logic [$clog2(N)-1:0] gnt_id
);

  localparam int PW = $clog2(N);

  logic [PW-1:0] ptr_q;
  logic [PW-1:0] ptr_d;
  logic [PW-1:0] idx;
  logic          found;

  // Scan ptr+1, ptr+2, ... wrapping at N; the first active request wins.
  always_comb begin
    gnt    = '0;
    gnt_id = '0;
    found  = 1'b0;
    idx    = '0;
    for (int k = 1; k <= N; k++) begin
      idx = PW'((int'(ptr_q) + k) % N);
      if (!found && req[idx]) begin
        gnt[idx] = 1'b1;
        gnt_id   = idx;
        found    = 1'b1;
      end
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (advance) begin
      ptr_d = gnt_id;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q <= PW'(N - 1);
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/cordic_hyp_arbiter.sv
// ----------------------------------------------------------------------------
// cordic_hyp_arbiter
//   Shares one pipelined hyperbolic CORDIC core (exp/ln, no backpressure) among
//   N_REQ requesters. One request per cycle is picked round-robin and issued;
//   a tag pipe carries the requester ID in step with the core so each result is
//   strobed back to its owner. Per-requester credits bound outstanding ops and
//   pause stops new accepts while in-flight ops drain.
//   Ports:
//     clk, rst      : clock, synchronous active-high reset
//     req_valid     : per-requester request valid
//     req_ready     : one-hot accept (transfer on valid & ready)
//     req_func      : per-requester function (0 = exp, 1 = ln)
//     req_a         : per-requester operand, slice i = [2W*i +: 2W]
//     pause         : block new accepts; in-flight ops complete
//     rsp_valid     : one-hot result strobe to the owner
//     rsp_data      : shared result bus, holds between strobes
//     cordic_start  : core start
//     cordic_func   : core function select
//     cordic_a      : core operand a
//     cordic_b      : core operand b (always zero)
//     cordic_valid  : core result valid
//     cordic_f      : core result
//     idle          : nothing in flight and nothing waiting to issue
//     err_orphan    : sticky, a core result and its tag disagreed
// ----------------------------------------------------------------------------
module cordic_hyp_arbiter
  import cordic_pkg::*;
#(
  parameter int N_REQ   = 4,
  parameter int W       = 12,
  parameter int LAT     = cordic_latency(W),
  parameter int MAX_OUT = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N_REQ-1:0]       req_valid,
  output logic [N_REQ-1:0]       req_ready,
  input  logic [N_REQ-1:0]       req_func,
  input  logic [N_REQ*2*W-1:0]   req_a,
  input  logic                   pause,
  output logic [N_REQ-1:0]       rsp_valid,
  output logic [2*W-1:0]         rsp_data,
  output logic                   cordic_start,
  output logic                   cordic_func,
  output logic [2*W-1:0]         cordic_a,
  output logic [2*W-1:0]         cordic_b,
  input  logic                   cordic_valid,
  input  logic [2*W-1:0]         cordic_f,
  output logic                   idle,
  output logic                   err_orphan
);

  localparam int         IDW     = $clog2(N_REQ);
  localparam int         DW      = 2 * W;
  localparam int         TW      = 1 + IDW;
  localparam logic [3:0] CNT_MAX = 4'(MAX_OUT);

  logic [3:0]       cnt_q [N_REQ];
  logic [3:0]       cnt_d [N_REQ];
  logic [N_REQ-1:0] eligible;
  logic [N_REQ-1:0] gnt;
  logic [IDW-1:0]   gnt_id;
  logic             gnt_any;

  logic             start_q, start_d;
  logic             func_q, func_d;
  logic [DW-1:0]    a_q, a_d;
  logic [TW-1:0]    issue_tag_q, issue_tag_d;

  logic             tag_rst_n;
  logic [TW-1:0]    pipe_tag;
  tag_t             tag_out;

  logic [N_REQ-1:0] rel_q, rel_d;
  logic [N_REQ-1:0] rsp_valid_q, rsp_valid_d;
  logic [DW-1:0]    rsp_data_q, rsp_data_d;
  logic             err_orphan_q, err_orphan_d;
  logic             all_zero;

  // A requester may compete only while it has a credit left and the arbiter
  // is neither paused nor in reset; this keeps req_ready low during reset.
  always_comb begin
    eligible = '0;
    for (int i = 0; i < N_REQ; i++) begin
      eligible[i] = req_valid[i] & (cnt_q[i] < CNT_MAX) & ~pause & ~rst;
    end
  end

  rr_arbiter #(
    .N (N_REQ)
  ) u_rr_arbiter (
    .clk     (clk),
    .rst     (rst),
    .req     (eligible),
    .advance (gnt_any),
    .gnt     (gnt),
    .gnt_id  (gnt_id)
  );

  assign gnt_any   = |gnt;
  assign req_ready = gnt;

  // Issue register: the grantee's operand is muxed by the one-hot grant.
  // func/a hold when nothing is issued so the core inputs stay quiet.
  always_comb begin
    start_d     = gnt_any;
    func_d      = func_q;
    a_d         = a_q;
    issue_tag_d = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (gnt[i]) begin
        func_d = req_func[i];
        a_d    = req_a[i*DW +: DW];
      end
    end
    if (gnt_any) begin
      issue_tag_d = {1'b1, gnt_id};
    end
  end

  // The tag rides in the issue register alongside cordic_start, then through
  // LAT pipe stages, so it leaves the pipe in the cycle cordic_valid is due.
  assign tag_rst_n = ~rst;

  pipeline_registers #(
    .BIT_WIDTH        (TW),
    .NUMBER_OF_STAGES (LAT)
  ) u_tag_pipe (
    .clk      (clk),
    .rst_n    (tag_rst_n),
    .data_in  (issue_tag_q),
    .data_out (pipe_tag)
  );

  always_comb begin
    tag_out                = '0;
    tag_out.vld            = pipe_tag[TW-1];
    tag_out.id[IDW-1:0]    = pipe_tag[IDW-1:0];
  end

  // Return path. A tag with no matching core valid still frees its credit so
  // the requester cannot deadlock; either disagreement raises err_orphan.
  always_comb begin
    rel_d        = '0;
    rsp_valid_d  = '0;
    rsp_data_d   = rsp_data_q;
    err_orphan_d = err_orphan_q;
    if (tag_out.vld) begin
      for (int i = 0; i < N_REQ; i++) begin
        if (int'(tag_out.id) == i) begin
          rel_d[i] = 1'b1;
        end
      end
      if (cordic_valid) begin
        rsp_valid_d = rel_d;
        rsp_data_d  = cordic_f;
      end else begin
        err_orphan_d = 1'b1;
      end
    end else if (cordic_valid) begin
      err_orphan_d = 1'b1;
    end
  end

  // Credits count up on accept and down one cycle after the tag returns, so a
  // full requester is re-accepted in the cycle after its result strobe.
  always_comb begin
    for (int i = 0; i < N_REQ; i++) begin
      cnt_d[i] = cnt_q[i];
      if (gnt[i] && !rel_q[i]) begin
        cnt_d[i] = cnt_q[i] + 4'd1;
      end else if (!gnt[i] && rel_q[i]) begin
        cnt_d[i] = cnt_q[i] - 4'd1;
      end
    end
  end

  always_comb begin
    all_zero = 1'b1;
    for (int i = 0; i < N_REQ; i++) begin
      if (cnt_q[i] != 4'd0) begin
        all_zero = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < N_REQ; i++) begin
        cnt_q[i] <= '0;
      end
      start_q      <= 1'b0;
      func_q       <= FUNC_EXP;
      a_q          <= '0;
      issue_tag_q  <= '0;
      rel_q        <= '0;
      rsp_valid_q  <= '0;
      rsp_data_q   <= '0;
      err_orphan_q <= 1'b0;
    end else begin
      for (int i = 0; i < N_REQ; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
      start_q      <= start_d;
      func_q       <= func_d;
      a_q          <= a_d;
      issue_tag_q  <= issue_tag_d;
      rel_q        <= rel_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_data_q   <= rsp_data_d;
      err_orphan_q <= err_orphan_d;
    end
  end

  assign cordic_start = start_q;
  assign cordic_func  = func_q;
  assign cordic_a     = a_q;
  assign cordic_b     = '0;
  assign rsp_valid    = rsp_valid_q;
  assign rsp_data     = rsp_data_q;
  assign err_orphan   = err_orphan_q;
  assign idle         = rst | (all_zero & ~start_q);

endmodule
